// File: rtl/cordiv_sng.sv
// cordiv_sng - correlated stochastic-number generator for a CORDIV divider.
//
// Converts a binary dividend/divisor pair into two maximally correlated
// unipolar bitstreams (SCC = +1). Both streams are compared against one
// shared LFSR. A second LFSR produces the shift-register tap select for the
// divider. Each accepted start produces one stream of L = 2^BITWIDTH-1 bits,
// followed by a one-cycle done pulse.
//
// Ports:
//   clk          in  1         rising-edge clock
//   rst_n        in  1         asynchronous reset, active low
//   start        in  1         request a stream (sampled only while idle)
//   dividend_bin in  BITWIDTH  dividend operand
//   divisor_bin  in  BITWIDTH  divisor operand
//   hold         in  1         stall; freezes the stream while high
//   dividend     out 1         dividend stochastic bit
//   divisor      out 1         divisor stochastic bit
//   sel          out SELW      shift-register tap select
//   valid        out 1         dividend/divisor/sel are meaningful this cycle
//   busy         out 1         a stream is in progress (state == RUN)
//   done         out 1         one-cycle pulse after the last bit
//   sat          out 1         dividend was clamped to divisor; held until next start
//
// Handshake: a start seen in IDLE is accepted on that clock edge and the
// first bit appears in the next cycle. Afterwards every cycle with valid=1
// carries exactly one bit; hold=1 suppresses valid and freezes the stream.
// The consumer takes a bit whenever valid=1 (there is no back-pressure path
// other than hold). start is ignored while busy=1.

module cordiv_sng #(
    parameter int          BITWIDTH = 8,
    parameter logic [7:0]  SEED     = 8'h01,
    parameter logic [7:0]  SELSEED  = 8'hA5,
    parameter int          SRDEPTH  = 2,
    localparam int         SELW     = (SRDEPTH > 2) ? $clog2(SRDEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] dividend_bin,
    input  logic [BITWIDTH-1:0] divisor_bin,
    input  logic                hold,
    output logic                dividend,
    output logic                divisor,
    output logic [SELW-1:0]     sel,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic                sat
);

    localparam logic [BITWIDTH-1:0] SEED_W    = SEED[BITWIDTH-1:0];
    localparam logic [BITWIDTH-1:0] SELSEED_W = SELSEED[BITWIDTH-1:0];
    // Last bit index of a stream: cnt runs 0 .. L-1 = 2^BITWIDTH-2.
    localparam logic [BITWIDTH-1:0] LAST_IDX  = BITWIDTH'((1 << BITWIDTH) - 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Elaboration-time parameter checks.
    if (BITWIDTH < 4 || BITWIDTH > 8) begin : g_bad_width
        $error("cordiv_sng: BITWIDTH must be in 4..8");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("cordiv_sng: SEED must be nonzero in its low BITWIDTH bits");
    end
    if (SELSEED_W == '0 || SELSEED_W == SEED_W) begin : g_bad_selseed
        $error("cordiv_sng: SELSEED must be nonzero and differ from SEED");
    end
    if (SELW > BITWIDTH) begin : g_bad_srdepth
        $error("cordiv_sng: SRDEPTH too large for the sel LFSR width");
    end

    logic [0:0]          state;
    logic [BITWIDTH-1:0] rng;
    logic [BITWIDTH-1:0] srng;
    logic [BITWIDTH-1:0] cnt;
    logic [BITWIDTH-1:0] dividend_q;
    logic [BITWIDTH-1:0] divisor_q;
    logic [BITWIDTH-1:0] rng_next;
    logic [BITWIDTH-1:0] srng_next;

    // Maximal-length feedback taps. The register is viewed zero-extended to
    // 8 bits so every branch indexes in range whatever BITWIDTH is.
    function automatic logic lfsr_fb(input logic [7:0] r);
        case (BITWIDTH)
            4:       return r[3] ^ r[2];
            5:       return r[4] ^ r[2];
            6:       return r[5] ^ r[4];
            7:       return r[6] ^ r[5];
            default: return r[7] ^ r[5] ^ r[4] ^ r[3];
        endcase
    endfunction

    always_comb begin
        rng_next  = {rng[BITWIDTH-2:0],  lfsr_fb(8'(rng))};
        srng_next = {srng[BITWIDTH-2:0], lfsr_fb(8'(srng))};
    end

    assign busy     = (state == RUN);
    assign valid    = busy & ~hold;
    // Shared rng with <= makes every dividend 1 coincide with a divisor 1.
    assign dividend = valid & (rng <= dividend_q);
    assign divisor  = valid & (rng <= divisor_q);
    assign sel      = valid ? srng[SELW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rng        <= SEED_W;
            srng       <= SELSEED_W;
            cnt        <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            sat        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        divisor_q  <= divisor_bin;
                        // Clamp so the quotient never exceeds 1.
                        dividend_q <= (dividend_bin > divisor_bin) ? divisor_bin : dividend_bin;
                        sat        <= (dividend_bin > divisor_bin);
                        rng        <= SEED_W;
                        srng       <= SELSEED_W;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    if (valid) begin
                        rng  <= rng_next;
                        srng <= srng_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordiv_sng.sv
module tb_cordiv_sng;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: BITWIDTH=8, SRDEPTH=2 ----------------
    logic       start8 = 1'b0, hold8 = 1'b0;
    logic [7:0] dvd_bin8 = '0, dvs_bin8 = '0;
    logic       dvd8, dvs8, valid8, busy8, done8, sat8;
    logic [0:0] sel8;

    cordiv_sng u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .dividend_bin(dvd_bin8), .divisor_bin(dvs_bin8), .hold(hold8),
        .dividend(dvd8), .divisor(dvs8), .sel(sel8), .valid(valid8),
        .busy(busy8), .done(done8), .sat(sat8)
    );

    // ---------------- DUT B: BITWIDTH=4, SRDEPTH=4 ----------------
    logic       start4 = 1'b0, hold4 = 1'b0;
    logic [3:0] dvd_bin4 = '0, dvs_bin4 = '0;
    logic       dvd4, dvs4, valid4, busy4, done4, sat4;
    logic [1:0] sel4;

    cordiv_sng #(.BITWIDTH(4), .SRDEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .dividend_bin(dvd_bin4), .divisor_bin(dvs_bin4), .hold(hold4),
        .dividend(dvd4), .divisor(dvs4), .sel(sel4), .valid(valid4),
        .busy(busy4), .done(done4), .sat(sat4)
    );

    int total = 0;
    int bad   = 0;

    // Expected bit queues: {dividend, divisor, sel}
    logic [2:0] exp_q8[$];
    logic [3:0] exp_q4[$];
    logic [2:0] e8;
    logic [3:0] e4;

    // ---------------- reference model ----------------
    function automatic logic [7:0] lfsr_step(input logic [7:0] r, input int w);
        logic fb;
        case (w)
            4:       fb = r[3] ^ r[2];
            5:       fb = r[4] ^ r[2];
            6:       fb = r[5] ^ r[4];
            7:       fb = r[6] ^ r[5];
            default: fb = r[7] ^ r[5] ^ r[4] ^ r[3];
        endcase
        return ((r << 1) | 8'(fb)) & 8'((1 << w) - 1);
    endfunction

    task automatic push8(input int dq, input int vq);
        logic [7:0] r = 8'h01;
        logic [7:0] s = 8'hA5;
        logic a, b;
        for (int i = 0; i < 255; i++) begin
            a = (int'(r) <= dq);
            b = (int'(r) <= vq);
            exp_q8.push_back({a, b, s[0]});
            r = lfsr_step(r, 8);
            s = lfsr_step(s, 8);
        end
    endtask

    task automatic push4(input int dq, input int vq);
        logic [7:0] r = 8'h01;
        logic [7:0] s = 8'h05;
        logic a, b;
        for (int i = 0; i < 15; i++) begin
            a = (int'(r) <= dq);
            b = (int'(r) <= vq);
            exp_q4.push_back({a, b, s[1:0]});
            r = lfsr_step(r, 4);
            s = lfsr_step(s, 4);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        total++;
        if (valid8) begin
            if (exp_q8.size() == 0) begin
                bad++;
                $display("FAIL mon8_extra: got bit=%b with no expected bit left", {dvd8, dvs8, sel8});
            end else begin
                e8 = exp_q8.pop_front();
                if ({dvd8, dvs8, sel8} !== e8) begin
                    bad++;
                    $display("FAIL mon8_bit: got=%b exp=%b at %0t", {dvd8, dvs8, sel8}, e8, $time);
                end
            end
        end else if ({dvd8, dvs8, sel8} !== 3'b000) begin
            bad++;
            $display("FAIL mon8_idle: got=%b exp=000 at %0t", {dvd8, dvs8, sel8}, $time);
        end
    end

    always @(negedge clk) begin
        total++;
        if (valid4) begin
            if (exp_q4.size() == 0) begin
                bad++;
                $display("FAIL mon4_extra: got bit=%b with no expected bit left", {dvd4, dvs4, sel4});
            end else begin
                e4 = exp_q4.pop_front();
                if ({dvd4, dvs4, sel4} !== e4) begin
                    bad++;
                    $display("FAIL mon4_bit: got=%b exp=%b at %0t", {dvd4, dvs4, sel4}, e4, $time);
                end
            end
        end else if ({dvd4, dvs4, sel4} !== 4'b0000) begin
            bad++;
            $display("FAIL mon4_idle: got=%b exp=0000 at %0t", {dvd4, dvs4, sel4}, $time);
        end
    end

    // ---------------- driver tasks ----------------
    // Stream statistics gathered by observe8 (cycle c = T+c).
    int   o_nv, o_n1, o_n2, o_only1, o_only2, o_ndone, o_done_cyc, o_vhold, o_first_v;
    logic o_sat1, o_busy1;

    task automatic begin8(input int dvd, input int dvs);
        @(posedge clk); #1;
        dvd_bin8 = 8'(dvd);
        dvs_bin8 = 8'(dvs);
        start8   = 1'b1;
        push8((dvd > dvs) ? dvs : dvd, dvs);
    endtask

    task automatic observe8(input int ncyc, input int hold_from, input int hold_len,
                            input int late_at, input int late_dvd, input int late_dvs);
        o_nv = 0; o_n1 = 0; o_n2 = 0; o_only1 = 0; o_only2 = 0;
        o_ndone = 0; o_done_cyc = -1; o_vhold = 0; o_first_v = -1;
        o_sat1 = 1'bx; o_busy1 = 1'bx;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start8 = (c == late_at);
            if (c == late_at) begin
                dvd_bin8 = 8'(late_dvd);
                dvs_bin8 = 8'(late_dvs);
            end
            hold8 = (c >= hold_from) && (c < hold_from + hold_len);
            #1;
            if (valid8) begin
                o_nv++;
                if (o_first_v < 0) o_first_v = c;
            end
            if (dvd8) o_n1++;
            if (dvs8) o_n2++;
            if (dvd8 && !dvs8) o_only1++;
            if (dvs8 && !dvd8) o_only2++;
            if (hold8 && valid8) o_vhold++;
            if (done8) begin
                o_ndone++;
                o_done_cyc = c;
            end
            if (c == 1) begin
                o_sat1  = sat8;
                o_busy1 = busy8;
            end
        end
        hold8  = 1'b0;
        start8 = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dvd8, dvs8, sel8, valid8, busy8, done8, sat8} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outs8: got=%b exp=0000000", {dvd8, dvs8, sel8, valid8, busy8, done8, sat8});
        end
        total++;
        if ({dvd4, dvs4, sel4, valid4, busy4, done4, sat4} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outs4: got=%b exp=00000000", {dvd4, dvs4, sel4, valid4, busy4, done4, sat4});
        end
        rst_n = 1'b1;
        // hold in IDLE must not start anything
        hold8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b valid=%b exp busy=0 valid=0", busy8, valid8);
        end
        hold8 = 1'b0;
    endtask

    task automatic test_count;
        begin8(64, 192);
        observe8(260, -1, 0, -1, 0, 0);
        total++; if (o_nv !== 255)       begin bad++; $display("FAIL count_valid: got=%0d exp=255", o_nv); end
        total++; if (o_n1 !== 64)        begin bad++; $display("FAIL count_dvd_ones: got=%0d exp=64", o_n1); end
        total++; if (o_n2 !== 192)       begin bad++; $display("FAIL count_dvs_ones: got=%0d exp=192", o_n2); end
        total++; if (o_only1 !== 0)      begin bad++; $display("FAIL count_corr: dividend-only cycles got=%0d exp=0", o_only1); end
        total++; if (o_ndone !== 1)      begin bad++; $display("FAIL count_done_pulses: got=%0d exp=1", o_ndone); end
        total++; if (o_done_cyc !== 256) begin bad++; $display("FAIL count_done_cycle: got=%0d exp=256", o_done_cyc); end
        total++; if (o_first_v !== 1)    begin bad++; $display("FAIL count_latency: first valid got=%0d exp=1", o_first_v); end
        total++; if (o_busy1 !== 1'b1)   begin bad++; $display("FAIL count_busy: got=%b exp=1", o_busy1); end
        total++; if (o_sat1 !== 1'b0)    begin bad++; $display("FAIL count_sat: got=%b exp=0", o_sat1); end
        total++; if (exp_q8.size() !== 0) begin bad++; $display("FAIL count_queue: left=%0d exp=0", exp_q8.size()); end
    endtask

    task automatic test_clamp;
        begin8(200, 100);
        observe8(258, -1, 0, -1, 0, 0);
        total++; if (o_sat1 !== 1'b1)    begin bad++; $display("FAIL clamp_sat: got=%b exp=1", o_sat1); end
        total++; if (sat8 !== 1'b1)      begin bad++; $display("FAIL clamp_sat_held: got=%b exp=1", sat8); end
        total++; if (o_n1 !== 100)       begin bad++; $display("FAIL clamp_dvd_ones: got=%0d exp=100", o_n1); end
        total++; if (o_n2 !== 100)       begin bad++; $display("FAIL clamp_dvs_ones: got=%0d exp=100", o_n2); end
        total++; if (o_only1 + o_only2 !== 0) begin bad++; $display("FAIL clamp_identical: differing cycles got=%0d exp=0", o_only1 + o_only2); end
        total++; if (exp_q8.size() !== 0) begin bad++; $display("FAIL clamp_queue: left=%0d exp=0", exp_q8.size()); end
    endtask

    task automatic test_hold;
        begin8(37, 211);
        observe8(270, 50, 10, -1, 0, 0);
        total++; if (o_vhold !== 0)      begin bad++; $display("FAIL hold_valid_low: valid during hold got=%0d exp=0", o_vhold); end
        total++; if (o_nv !== 255)       begin bad++; $display("FAIL hold_valid: got=%0d exp=255", o_nv); end
        total++; if (o_done_cyc !== 266) begin bad++; $display("FAIL hold_done_cycle: got=%0d exp=266", o_done_cyc); end
        total++; if (o_n1 !== 37 || o_n2 !== 211) begin bad++; $display("FAIL hold_ones: got=%0d/%0d exp=37/211", o_n1, o_n2); end
        total++; if (exp_q8.size() !== 0) begin bad++; $display("FAIL hold_queue: left=%0d exp=0", exp_q8.size()); end
    endtask

    task automatic test_start_in_run;
        begin8(30, 90);
        observe8(258, -1, 0, 100, 7, 250);
        total++; if (o_n1 !== 30 || o_n2 !== 90) begin bad++; $display("FAIL ignore_start_ones: got=%0d/%0d exp=30/90", o_n1, o_n2); end
        total++; if (o_done_cyc !== 256 || o_ndone !== 1) begin bad++; $display("FAIL ignore_start_done: cycle=%0d pulses=%0d exp=256/1", o_done_cyc, o_ndone); end
        total++; if (busy8 !== 1'b0)     begin bad++; $display("FAIL ignore_start_idle: busy got=%b exp=0", busy8); end
        total++; if (exp_q8.size() !== 0) begin bad++; $display("FAIL ignore_start_queue: left=%0d exp=0", exp_q8.size()); end
    endtask

    task automatic test_back_to_back;
        begin8(5, 250);
        observe8(256, -1, 0, -1, 0, 0);
        total++; if (o_done_cyc !== 256 || busy8 !== 1'b0) begin bad++; $display("FAIL b2b_done: cycle=%0d busy=%b exp=256/0", o_done_cyc, busy8); end
        // Still inside the done cycle: request the next stream.
        dvd_bin8 = 8'd100;
        dvs_bin8 = 8'd120;
        start8   = 1'b1;
        push8(100, 120);
        observe8(258, -1, 0, -1, 0, 0);
        total++; if (o_first_v !== 1)    begin bad++; $display("FAIL b2b_first_bit: cycle after done got=%0d exp=1", o_first_v); end
        total++; if (o_n1 !== 100 || o_n2 !== 120) begin bad++; $display("FAIL b2b_ones: got=%0d/%0d exp=100/120", o_n1, o_n2); end
        total++; if (o_done_cyc !== 256) begin bad++; $display("FAIL b2b_done2: got=%0d exp=256", o_done_cyc); end
        total++; if (exp_q8.size() !== 0) begin bad++; $display("FAIL b2b_queue: left=%0d exp=0", exp_q8.size()); end
    endtask

    task automatic test_reset_mid;
        begin8(150, 100);
        observe8(120, -1, 0, -1, 0, 0);
        rst_n = 1'b0;
        exp_q8.delete();
        #1;
        total++;
        if ({dvd8, dvs8, sel8, valid8, busy8, done8, sat8} !== 7'b0) begin
            bad++;
            $display("FAIL reset_mid_outs: got=%b exp=0000000", {dvd8, dvs8, sel8, valid8, busy8, done8, sat8});
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_mid_no_resume: busy got=%b exp=0", busy8); end
        begin8(40, 80);
        observe8(258, -1, 0, -1, 0, 0);
        total++; if (o_nv !== 255)       begin bad++; $display("FAIL reset_mid_valid: got=%0d exp=255", o_nv); end
        total++; if (o_n1 !== 40 || o_n2 !== 80) begin bad++; $display("FAIL reset_mid_ones: got=%0d/%0d exp=40/80", o_n1, o_n2); end
        total++; if (o_done_cyc !== 256) begin bad++; $display("FAIL reset_mid_done: got=%0d exp=256", o_done_cyc); end
        total++; if (exp_q8.size() !== 0) begin bad++; $display("FAIL reset_mid_queue: left=%0d exp=0", exp_q8.size()); end
    endtask

    task automatic test_width4;
        int nv = 0, n1 = 0, n2 = 0, done_cyc = -1;
        logic [3:0] selmask = 4'b0;
        @(posedge clk); #1;
        dvd_bin4 = 4'd0;
        dvs_bin4 = 4'd15;
        start4   = 1'b1;
        push4(0, 15);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
            hold4  = ($urandom_range(0, 3) == 0) && (c < 8);
            #1;
            if (valid4) begin
                nv++;
                selmask[sel4] = 1'b1;
            end
            if (dvd4) n1++;
            if (dvs4) n2++;
            if (done4) done_cyc = c;
        end
        hold4 = 1'b0;
        // Random holds may delay done; drain until it appears (bounded).
        for (int c = 21; c <= 40 && done_cyc < 0; c++) begin
            @(posedge clk); #2;
            if (valid4) begin nv++; selmask[sel4] = 1'b1; end
            if (dvd4) n1++;
            if (dvs4) n2++;
            if (done4) done_cyc = c;
        end
        total++; if (nv !== 15)         begin bad++; $display("FAIL w4_valid: got=%0d exp=15", nv); end
        total++; if (n1 !== 0)          begin bad++; $display("FAIL w4_dvd_ones: got=%0d exp=0", n1); end
        total++; if (n2 !== 15)         begin bad++; $display("FAIL w4_dvs_ones: got=%0d exp=15", n2); end
        total++; if (done_cyc < 16)     begin bad++; $display("FAIL w4_done: got=%0d exp>=16", done_cyc); end
        total++; if (selmask !== 4'hF)  begin bad++; $display("FAIL w4_sel_values: got=%b exp=1111", selmask); end
        total++; if (sat4 !== 1'b0)     begin bad++; $display("FAIL w4_sat: got=%b exp=0", sat4); end
        total++; if (exp_q4.size() !== 0) begin bad++; $display("FAIL w4_queue: left=%0d exp=0", exp_q4.size()); end
    endtask

    task automatic test_width4_exact;
        int done_cyc = -1;
        @(posedge clk); #1;
        dvd_bin4 = 4'd9;
        dvs_bin4 = 4'd4;
        start4   = 1'b1;
        push4(4, 4);
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
            #1;
            if (c == 1) begin
                total++; if (sat4 !== 1'b1) begin bad++; $display("FAIL w4_clamp_sat: got=%b exp=1", sat4); end
            end
            if (done4) done_cyc = c;
        end
        total++; if (done_cyc !== 16)   begin bad++; $display("FAIL w4_done_cycle: got=%0d exp=16", done_cyc); end
        total++; if (exp_q4.size() !== 0) begin bad++; $display("FAIL w4_clamp_queue: left=%0d exp=0", exp_q4.size()); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_count();
        test_clamp();
        test_hold();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid();
        test_width4();
        test_width4_exact();
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
